// File: rtl/capture_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | capture_sequencer_if                                                        |
// | Control, configuration and capture-grant bundle for capture_sequencer.      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface capture_sequencer_if #(
   parameter int NCHAN        = 8,
   parameter int NBEAMS       = 2,
   parameter int CAP_LEN_BITS = 10,
   parameter int HOLDOFF_BITS = 16
);
   localparam int c_SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   logic                    arm_i;
   logic                    disarm_i;
   logic                    auto_rearm_i;
   logic [NCHAN-1:0]        chan_mask_i;
   logic [NBEAMS-1:0]       beam_mask_i;
   logic [CAP_LEN_BITS-1:0] cap_len_i;
   logic [HOLDOFF_BITS-1:0] holdoff_i;
   logic [NBEAMS-1:0]       trig_i;
   logic [c_SEL_W-1:0]      sel_o;
   logic                    cap_valid_o;
   logic                    cap_first_o;
   logic                    cap_last_o;
   logic                    busy_o;
   logic [NBEAMS-1:0]       trig_beams_o;
   logic [15:0]             trig_count_o;

   modport master (
      output arm_i, disarm_i, auto_rearm_i, chan_mask_i, beam_mask_i,
             cap_len_i, holdoff_i, trig_i,
      input  sel_o, cap_valid_o, cap_first_o, cap_last_o, busy_o,
             trig_beams_o, trig_count_o
   );

   modport slave (
      input  arm_i, disarm_i, auto_rearm_i, chan_mask_i, beam_mask_i,
             cap_len_i, holdoff_i, trig_i,
      output sel_o, cap_valid_o, cap_first_o, cap_last_o, busy_o,
             trig_beams_o, trig_count_o
   );
endinterface
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | capture_sequencer                                                           |
// | Trigger-driven scheduler granting fixed-length capture bursts to channels.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module capture_sequencer #(
   parameter int NCHAN        = 8,
   parameter int NBEAMS       = 2,
   parameter int CAP_LEN_BITS = 10,
   parameter int HOLDOFF_BITS = 16
) (
   input  logic               aclk,
   input  logic               reset_i,
   capture_sequencer_if.slave bus
);
   localparam int c_SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_CAPT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t                  r_state,        w_state_nxt;
   logic [NCHAN-1:0]        r_mask,         w_mask_nxt;
   logic [CAP_LEN_BITS-1:0] r_len,          w_len_nxt;
   logic [HOLDOFF_BITS-1:0] r_holdoff,      w_holdoff_nxt;
   logic [CAP_LEN_BITS-1:0] r_beat,         w_beat_nxt;
   logic [HOLDOFF_BITS-1:0] r_hold_cnt,     w_hold_cnt_nxt;
   logic                    r_run,          w_run_nxt;
   logic                    r_disarm_pend,  w_disarm_pend_nxt;
   logic [c_SEL_W-1:0]      r_sel,          w_sel_nxt;
   logic                    r_cap_valid,    w_cap_valid_nxt;
   logic                    r_cap_first,    w_cap_first_nxt;
   logic                    r_cap_last,     w_cap_last_nxt;
   logic                    r_busy,         w_busy_nxt;
   logic [NBEAMS-1:0]       r_trig_beams,   w_trig_beams_nxt;
   logic [15:0]             r_trig_count,   w_trig_count_nxt;

   logic [NBEAMS-1:0]       w_hit_vec;
   logic                    w_hit;
   logic [c_SEL_W:0]        w_first_scan;
   logic [c_SEL_W:0]        w_next_scan;
   logic [CAP_LEN_BITS-1:0] w_beat_inc;
   logic [CAP_LEN_BITS-1:0] w_len_m1;

   // Returns {found, index} of the lowest set mask bit at or above lo.
   function automatic logic [c_SEL_W:0] f_scan(input logic [NCHAN-1:0] mask, input int lo);
      logic [c_SEL_W:0] res;
      res = '0;
      for (int i = NCHAN - 1; i >= 0; i--) begin
         if (mask[i] && (i >= lo)) begin
            res = {1'b1, c_SEL_W'(i)};
         end
      end
      return res;
   endfunction

   assign w_hit_vec    = bus.trig_i & bus.beam_mask_i;
   assign w_hit        = |w_hit_vec;
   assign w_first_scan = f_scan(r_mask, 0);
   assign w_next_scan  = f_scan(r_mask, int'(r_sel) + 1);
   assign w_beat_inc   = r_beat + CAP_LEN_BITS'(1);
   assign w_len_m1     = r_len - CAP_LEN_BITS'(1);

   always_comb begin
      w_state_nxt       = r_state;
      w_mask_nxt        = r_mask;
      w_len_nxt         = r_len;
      w_holdoff_nxt     = r_holdoff;
      w_beat_nxt        = r_beat;
      w_hold_cnt_nxt    = r_hold_cnt;
      w_run_nxt         = r_run;
      w_disarm_pend_nxt = r_disarm_pend;
      w_sel_nxt         = r_sel;
      w_cap_valid_nxt   = 1'b0;
      w_cap_first_nxt   = 1'b0;
      w_cap_last_nxt    = 1'b0;
      w_trig_beams_nxt  = r_trig_beams;
      w_trig_count_nxt  = r_trig_count;

      case (r_state)
         S_IDLE: begin
            if (bus.arm_i && (bus.chan_mask_i != '0)) begin
               w_state_nxt = S_ARMED;
            end
         end

         S_ARMED: begin
            if (bus.disarm_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_hit) begin
               w_state_nxt      = S_CAPT;
               w_mask_nxt       = bus.chan_mask_i;
               w_len_nxt        = (bus.cap_len_i == '0) ? CAP_LEN_BITS'(1) : bus.cap_len_i;
               w_holdoff_nxt    = bus.holdoff_i;
               w_trig_beams_nxt = w_hit_vec;
               w_run_nxt        = 1'b0;
               w_trig_count_nxt = (r_trig_count == 16'hFFFF) ? r_trig_count
                                                             : r_trig_count + 16'd1;
            end
         end

         S_CAPT: begin
            if (bus.disarm_i) begin
               w_disarm_pend_nxt = 1'b1;
            end
            // The first CAPT cycle only selects the channel; beats follow back to back.
            if (!r_run) begin
               w_run_nxt       = 1'b1;
               w_sel_nxt       = w_first_scan[c_SEL_W-1:0];
               w_beat_nxt      = '0;
               w_cap_valid_nxt = 1'b1;
               w_cap_first_nxt = 1'b1;
               w_cap_last_nxt  = (r_len == CAP_LEN_BITS'(1));
            end else if (r_cap_last) begin
               if (w_next_scan[c_SEL_W]) begin
                  w_sel_nxt       = w_next_scan[c_SEL_W-1:0];
                  w_beat_nxt      = '0;
                  w_cap_valid_nxt = 1'b1;
                  w_cap_first_nxt = 1'b1;
                  w_cap_last_nxt  = (r_len == CAP_LEN_BITS'(1));
               end else begin
                  w_state_nxt    = S_HOLD;
                  w_run_nxt      = 1'b0;
                  w_hold_cnt_nxt = (r_holdoff == '0) ? HOLDOFF_BITS'(1) : r_holdoff;
               end
            end else begin
               w_beat_nxt      = w_beat_inc;
               w_cap_valid_nxt = 1'b1;
               w_cap_last_nxt  = (w_beat_inc == w_len_m1);
            end
         end

         S_HOLD: begin
            if (r_hold_cnt <= HOLDOFF_BITS'(1)) begin
               w_state_nxt       = (bus.auto_rearm_i && !r_disarm_pend && !bus.disarm_i)
                                   ? S_ARMED : S_IDLE;
               w_disarm_pend_nxt = 1'b0;
               w_hold_cnt_nxt    = '0;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt - HOLDOFF_BITS'(1);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge aclk or posedge reset_i) begin
      if (reset_i) begin
         r_state       <= S_IDLE;
         r_mask        <= '0;
         r_len         <= '0;
         r_holdoff     <= '0;
         r_beat        <= '0;
         r_hold_cnt    <= '0;
         r_run         <= 1'b0;
         r_disarm_pend <= 1'b0;
         r_sel         <= '0;
         r_cap_valid   <= 1'b0;
         r_cap_first   <= 1'b0;
         r_cap_last    <= 1'b0;
         r_busy        <= 1'b0;
         r_trig_beams  <= '0;
         r_trig_count  <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_mask        <= w_mask_nxt;
         r_len         <= w_len_nxt;
         r_holdoff     <= w_holdoff_nxt;
         r_beat        <= w_beat_nxt;
         r_hold_cnt    <= w_hold_cnt_nxt;
         r_run         <= w_run_nxt;
         r_disarm_pend <= w_disarm_pend_nxt;
         r_sel         <= w_sel_nxt;
         r_cap_valid   <= w_cap_valid_nxt;
         r_cap_first   <= w_cap_first_nxt;
         r_cap_last    <= w_cap_last_nxt;
         r_busy        <= w_busy_nxt;
         r_trig_beams  <= w_trig_beams_nxt;
         r_trig_count  <= w_trig_count_nxt;
      end
   end

   assign bus.sel_o        = r_sel;
   assign bus.cap_valid_o  = r_cap_valid;
   assign bus.cap_first_o  = r_cap_first;
   assign bus.cap_last_o   = r_cap_last;
   assign bus.busy_o       = r_busy;
   assign bus.trig_beams_o = r_trig_beams;
   assign bus.trig_count_o = r_trig_count;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_capture_sequencer                                                        |
// | Directed self-checking bench for capture_sequencer.                         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_capture_sequencer;
   logic aclk;
   logic reset_i;
   int   n_checks;
   int   n_errors;

   capture_sequencer_if #(.NCHAN(8), .NBEAMS(2), .CAP_LEN_BITS(10), .HOLDOFF_BITS(16)) bus ();

   capture_sequencer #(.NCHAN(8), .NBEAMS(2), .CAP_LEN_BITS(10), .HOLDOFF_BITS(16)) dut (
      .aclk    (aclk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(negedge aclk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [2:0] exp_sel [9];
      exp_sel = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7};
      n_checks = 0;
      n_errors = 0;
      reset_i          = 1'b1;
      bus.arm_i        = 1'b0;
      bus.disarm_i     = 1'b0;
      bus.auto_rearm_i = 1'b0;
      bus.chan_mask_i  = '0;
      bus.beam_mask_i  = '0;
      bus.cap_len_i    = '0;
      bus.holdoff_i    = '0;
      bus.trig_i       = '0;
      tick(); tick();
      reset_i = 1'b0;
      chk("rst_valid", bus.cap_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_count", bus.trig_count_o, 0);
      chk("rst_sel", bus.sel_o, 0);

      // T1: triggers without arming, and arm with an empty mask
      bus.trig_i = 2'b11; bus.beam_mask_i = 2'b11;
      tick(); tick(); tick();
      chk("t1_valid", bus.cap_valid_o, 0);
      chk("t1_count", bus.trig_count_o, 0);
      chk("t1_busy", bus.busy_o, 0);
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0; tick();
      chk("t1_arm_empty", bus.busy_o, 0);
      bus.trig_i = 2'b00;

      // T2: three channels, three beats each, holdoff 4
      bus.chan_mask_i = 8'b1010_0100; bus.cap_len_i = 10'd3; bus.holdoff_i = 16'd4;
      bus.auto_rearm_i = 1'b0;
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
      chk("t2_armed_busy", bus.busy_o, 1);
      bus.trig_i = 2'b01; tick(); bus.trig_i = 2'b00;
      bus.chan_mask_i = 8'hFF; bus.cap_len_i = 10'd1; bus.holdoff_i = 16'd0;
      chk("t2_latency", bus.cap_valid_o, 0);
      chk("t2_count", bus.trig_count_o, 1);
      chk("t2_beams", bus.trig_beams_o, 2'b01);
      for (int k = 0; k < 9; k++) begin
         tick();
         chk("t2_valid", bus.cap_valid_o, 1);
         chk("t2_sel", bus.sel_o, exp_sel[k]);
         chk("t2_first", bus.cap_first_o, (k % 3) == 0);
         chk("t2_last", bus.cap_last_o, (k % 3) == 2);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t2_hold_valid", bus.cap_valid_o, 0);
         chk("t2_hold_busy", bus.busy_o, 1);
      end
      tick();
      chk("t2_idle", bus.busy_o, 0);
      chk("t2_sel_kept", bus.sel_o, 7);
      chk("t2_count_end", bus.trig_count_o, 1);

      // T3: beam mask filtering
      bus.chan_mask_i = 8'h02; bus.cap_len_i = 10'd2; bus.holdoff_i = 16'd1;
      bus.beam_mask_i = 2'b10;
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
      bus.trig_i = 2'b01; tick(); bus.trig_i = 2'b00; tick();
      chk("t3_masked_busy", bus.busy_o, 1);
      chk("t3_masked_count", bus.trig_count_o, 1);
      chk("t3_masked_valid", bus.cap_valid_o, 0);
      bus.trig_i = 2'b10; tick(); bus.trig_i = 2'b00;
      chk("t3_count", bus.trig_count_o, 2);
      chk("t3_beams", bus.trig_beams_o, 2'b10);
      tick();
      chk("t3_b0_valid", bus.cap_valid_o, 1);
      chk("t3_b0_sel", bus.sel_o, 1);
      chk("t3_b0_first", bus.cap_first_o, 1);
      chk("t3_b0_last", bus.cap_last_o, 0);
      tick();
      chk("t3_b1_first", bus.cap_first_o, 0);
      chk("t3_b1_last", bus.cap_last_o, 1);
      tick();
      chk("t3_hold_valid", bus.cap_valid_o, 0);
      tick();
      chk("t3_idle", bus.busy_o, 0);

      // T4: zero length becomes one beat; auto re-arm
      bus.chan_mask_i = 8'h01; bus.cap_len_i = 10'd0; bus.holdoff_i = 16'd2;
      bus.auto_rearm_i = 1'b1; bus.beam_mask_i = 2'b11;
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
      bus.trig_i = 2'b01; tick(); bus.trig_i = 2'b00;
      chk("t4_count", bus.trig_count_o, 3);
      tick();
      chk("t4_valid", bus.cap_valid_o, 1);
      chk("t4_sel", bus.sel_o, 0);
      chk("t4_first", bus.cap_first_o, 1);
      chk("t4_last", bus.cap_last_o, 1);
      tick();
      chk("t4_one_beat", bus.cap_valid_o, 0);
      tick(); tick();
      chk("t4_rearmed_busy", bus.busy_o, 1);
      bus.trig_i = 2'b10; tick(); bus.trig_i = 2'b00;
      chk("t4_count2", bus.trig_count_o, 4);
      tick();
      chk("t4_valid2", bus.cap_valid_o, 1);
      tick();
      bus.auto_rearm_i = 1'b0;
      tick(); tick();
      chk("t4_idle", bus.busy_o, 0);

      // T5: disarm beats a same-cycle trigger; disarm during capture
      bus.cap_len_i = 10'd1; bus.holdoff_i = 16'd1; bus.auto_rearm_i = 1'b1;
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
      bus.disarm_i = 1'b1; bus.trig_i = 2'b01; tick();
      bus.disarm_i = 1'b0; bus.trig_i = 2'b00;
      chk("t5_disarm_busy", bus.busy_o, 0);
      chk("t5_disarm_count", bus.trig_count_o, 4);
      tick();
      chk("t5_disarm_valid", bus.cap_valid_o, 0);
      bus.chan_mask_i = 8'h03; bus.cap_len_i = 10'd2;
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
      bus.trig_i = 2'b01; tick(); bus.trig_i = 2'b00;
      chk("t5_count", bus.trig_count_o, 5);
      tick();
      chk("t5_b0_sel", bus.sel_o, 0);
      bus.disarm_i = 1'b1; tick(); bus.disarm_i = 1'b0;
      chk("t5_b1_last", bus.cap_last_o, 1);
      tick();
      chk("t5_c1_valid", bus.cap_valid_o, 1);
      chk("t5_c1_sel", bus.sel_o, 1);
      tick();
      chk("t5_c1_last", bus.cap_last_o, 1);
      tick();
      chk("t5_hold", bus.busy_o, 1);
      tick();
      chk("t5_idle", bus.busy_o, 0);

      // T6: asynchronous reset mid-burst
      bus.chan_mask_i = 8'hFF; bus.cap_len_i = 10'd4; bus.auto_rearm_i = 1'b0;
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
      bus.trig_i = 2'b01; tick(); bus.trig_i = 2'b00;
      tick(); tick();
      chk("t6_pre_valid", bus.cap_valid_o, 1);
      #2 reset_i = 1'b1;
      #1;
      chk("t6_async_valid", bus.cap_valid_o, 0);
      chk("t6_async_first", bus.cap_first_o, 0);
      chk("t6_async_busy", bus.busy_o, 0);
      chk("t6_async_count", bus.trig_count_o, 0);
      tick();
      reset_i = 1'b0;

      // Saturation of the trigger counter
      force dut.r_trig_count = 16'hFFFE;
      tick();
      release dut.r_trig_count;
      chk("t6_preload", bus.trig_count_o, 16'hFFFE);
      bus.chan_mask_i = 8'h01; bus.cap_len_i = 10'd1; bus.holdoff_i = 16'd1;
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
      bus.trig_i = 2'b01; tick(); bus.trig_i = 2'b00;
      chk("t6_count_max", bus.trig_count_o, 16'hFFFF);
      tick(); tick(); tick();
      chk("t6_idle", bus.busy_o, 0);
      bus.arm_i = 1'b1; tick(); bus.arm_i = 1'b0;
      bus.trig_i = 2'b01; tick(); bus.trig_i = 2'b00;
      chk("t6_count_sat", bus.trig_count_o, 16'hFFFF);
      tick();
      chk("t6_sat_valid", bus.cap_valid_o, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
